// File: rtl/feature_if.sv
// Score stream between pipeline stages: one score per beat with a valid/ready
// handshake. The producer holds valid and its data until ready is seen.
interface feature_if #(
    parameter int FEATURE_W = 32
);
    logic                 valid;
    logic                 ready;
    logic [FEATURE_W-1:0] features [1];

    modport master (
        output valid,
        output features,
        input  ready
    );

    modport slave (
        input  valid,
        input  features,
        output ready
    );
endinterface

// File: rtl/argmax_classifier.sv
// Terminal stage of the classifier pipeline. It takes one frame of
// NUM_CLASSES signed scores and tracks the running maximum, keeping the
// lowest index on ties. It then holds the winning index and score on a
// valid/ready result port until the result is taken.
module argmax_classifier #(
    parameter int NUM_CLASSES = 10,
    parameter int FEATURE_W   = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    feature_if.slave             features_in,
    output logic                 class_valid,
    input  logic                 class_ready,
    output logic [3:0]           class_index,
    output logic [FEATURE_W-1:0] class_score,
    output logic [15:0]          frame_count
);

    localparam logic [3:0] LAST_BEAT = 4'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        HOLD
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           beat_q, beat_d;
    logic [FEATURE_W-1:0] max_val_q, max_val_d;
    logic [3:0]           max_idx_q, max_idx_d;
    logic [3:0]           class_index_q, class_index_d;
    logic [FEATURE_W-1:0] class_score_q, class_score_d;
    logic [15:0]          frame_count_q, frame_count_d;

    logic                 ready_o;
    logic                 class_valid_o;
    logic                 accept;
    logic                 handshake;
    logic                 last_beat;
    logic [FEATURE_W-1:0] score;
    logic [FEATURE_W-1:0] new_max_val;
    logic [3:0]           new_max_idx;

    assign score     = features_in.features[0];
    assign accept    = (state_q == RECV) && features_in.valid;
    assign handshake = (state_q == HOLD) && class_ready;
    assign last_beat = (beat_q == LAST_BEAT);

    // State register, cleared asynchronously so a reset discards any partial frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: wait for the last beat, then wait for the result handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: state_d = RECV;
            RECV: if (accept && last_beat) state_d = HOLD;
            HOLD: if (class_ready) state_d = RECV;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs come straight from the state register, with no path from the inputs.
    always_comb begin
        ready_o       = 1'b0;
        class_valid_o = 1'b0;
        unique case (state_q)
            IDLE: ;
            RECV: ready_o = 1'b1;
            HOLD: class_valid_o = 1'b1;
            default: ;
        endcase
    end

    assign features_in.ready = ready_o;
    assign class_valid       = class_valid_o;

    // Running maximum. Beat 0 always loads. Later beats win only when strictly greater, so ties keep the lowest index.
    always_comb begin
        new_max_val = max_val_q;
        new_max_idx = max_idx_q;
        if ((beat_q == 4'd0) || ($signed(score) > $signed(max_val_q))) begin
            new_max_val = score;
            new_max_idx = beat_q;
        end
    end

    // Datapath next values: the beat counter, the max tracker, the result capture and the frame counter.
    always_comb begin
        beat_d        = beat_q;
        max_val_d     = max_val_q;
        max_idx_d     = max_idx_q;
        class_index_d = class_index_q;
        class_score_d = class_score_q;
        frame_count_d = frame_count_q;
        if (accept) begin
            max_val_d = new_max_val;
            max_idx_d = new_max_idx;
            if (last_beat) begin
                class_index_d = new_max_idx;
                class_score_d = new_max_val;
                beat_d        = 4'd0;
            end else begin
                beat_d = beat_q + 4'd1;
            end
        end
        if (handshake) begin
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    // Datapath registers, all cleared by reset so nothing carries over into the next frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            beat_q        <= '0;
            max_val_q     <= '0;
            max_idx_q     <= '0;
            class_index_q <= '0;
            class_score_q <= '0;
            frame_count_q <= '0;
        end else begin
            beat_q        <= beat_d;
            max_val_q     <= max_val_d;
            max_idx_q     <= max_idx_d;
            class_index_q <= class_index_d;
            class_score_q <= class_score_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign class_index = class_index_q;
    assign class_score = class_score_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed bench for argmax_classifier: it sends frames with hand-computed
// winners and checks the handshake timing, backpressure, reset and counter wrap.
module tb_argmax_classifier;

    logic        clock;
    logic        reset_n;
    logic        class_valid;
    logic        class_ready;
    logic [3:0]  class_index;
    logic [31:0] class_score;
    logic [15:0] frame_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] fs [10];
    int          gp [10];

    feature_if #(.FEATURE_W(32)) fifc ();

    argmax_classifier #(.NUM_CLASSES(10), .FEATURE_W(32)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .features_in (fifc),
        .class_valid (class_valid),
        .class_ready (class_ready),
        .class_index (class_index),
        .class_score (class_score),
        .frame_count (frame_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Called at a negedge. Drives one beat and returns at the negedge after the edge that accepts it.
    task automatic sendBeat(input logic [31:0] s, input int gap);
        int waitCnt;
        waitCnt = 0;
        fifc.valid = 1'b0;
        repeat (gap) @(negedge clock);
        while (!fifc.ready && waitCnt < 50) begin
            @(negedge clock);
            waitCnt++;
        end
        if (!fifc.ready) checkOutput("ready_timeout", 32'(fifc.ready), 32'd1);
        fifc.valid       = 1'b1;
        fifc.features[0] = s;
        @(negedge clock);
        fifc.valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] scores [10], input int gaps [10]);
        for (int i = 0; i < 10; i++) sendBeat(scores[i], gaps[i]);
    endtask

    task automatic expectResult(input string tag, input logic [3:0] idx, input logic [31:0] sc);
        checkOutput({tag, "_valid"}, 32'(class_valid), 32'd1);
        checkOutput({tag, "_ready_low"}, 32'(fifc.ready), 32'd0);
        checkOutput({tag, "_index"}, 32'(class_index), 32'(idx));
        checkOutput({tag, "_score"}, class_score, sc);
    endtask

    // Takes the pending result with one handshake cycle and checks that the counter stepped.
    task automatic takeResult(input string tag, input logic [15:0] expCount);
        class_ready = 1'b1;
        @(negedge clock);
        class_ready = 1'b0;
        checkOutput({tag, "_count"}, 32'(frame_count), 32'(expCount));
        checkOutput({tag, "_valid_low"}, 32'(class_valid), 32'd0);
        checkOutput({tag, "_ready_back"}, 32'(fifc.ready), 32'd1);
    endtask

    initial begin
        reset_n          = 1'b1;
        class_ready      = 1'b0;
        fifc.valid       = 1'b0;
        fifc.features[0] = '0;
        for (int i = 0; i < 10; i++) gp[i] = 0;

        #1 reset_n = 1'b0;
        @(negedge clock);
        checkOutput("rst_ready", 32'(fifc.ready), 32'd0);
        checkOutput("rst_valid", 32'(class_valid), 32'd0);
        checkOutput("rst_count", 32'(frame_count), 32'd0);
        checkOutput("rst_index", 32'(class_index), 32'd0);
        checkOutput("rst_score", class_score, 32'd0);

        reset_n = 1'b1;
        #1 checkOutput("idle_ready", 32'(fifc.ready), 32'd0);
        @(negedge clock);
        checkOutput("recv_ready", 32'(fifc.ready), 32'd1);
        checkOutput("recv_valid", 32'(class_valid), 32'd0);

        // Ascending frame with class_ready tied high: the result is taken in its single HOLD cycle.
        class_ready = 1'b1;
        for (int i = 0; i < 10; i++) fs[i] = 32'(i);
        applyStimulus(fs, gp);
        expectResult("asc", 4'd9, 32'd9);
        checkOutput("asc_count_before", 32'(frame_count), 32'd0);
        @(negedge clock);
        checkOutput("asc_count", 32'(frame_count), 32'd1);
        checkOutput("asc_ready_back", 32'(fifc.ready), 32'd1);
        checkOutput("asc_valid_low", 32'(class_valid), 32'd0);
        class_ready = 1'b0;

        // Negative scores with a repeated maximum keep the first index.
        fs = '{32'(-5), 32'(-2), 32'(-7), 32'(-2), 32'(-9), 32'(-3), 32'(-2), 32'(-8), 32'(-6), 32'(-4)};
        applyStimulus(fs, gp);
        expectResult("neg", 4'd1, 32'hFFFF_FFFE);
        takeResult("neg", 16'd2);

        // All scores equal to the most negative value: index 0 wins.
        for (int i = 0; i < 10; i++) fs[i] = 32'h8000_0000;
        applyStimulus(fs, gp);
        expectResult("min", 4'd0, 32'h8000_0000);
        takeResult("min", 16'd3);

        // Input gaps and a 20-cycle hold under backpressure.
        fs = '{32'd3, 32'd7, 32'd7, 32'd1, 32'd0, 32'd12, 32'd4, 32'd12, 32'd2, 32'd5};
        gp = '{2, 0, 1, 3, 0, 0, 2, 1, 0, 4};
        applyStimulus(fs, gp);
        for (int i = 0; i < 10; i++) gp[i] = 0;
        for (int c = 0; c < 20; c++) begin
            expectResult("hold", 4'd5, 32'd12);
            checkOutput("hold_count", 32'(frame_count), 32'd3);
            @(negedge clock);
        end
        takeResult("hold", 16'd4);

        // A reset in the middle of a frame discards it and clears the counter.
        for (int i = 0; i < 5; i++) sendBeat(32'(20 + 10 * i), 0);
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_count", 32'(frame_count), 32'd0);
        checkOutput("midrst_ready", 32'(fifc.ready), 32'd0);
        checkOutput("midrst_valid", 32'(class_valid), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) fs[i] = 32'(9 - i);
        applyStimulus(fs, gp);
        expectResult("after_rst", 4'd0, 32'd9);
        takeResult("after_rst", 16'd1);

        // Counter wrap: preload the counter near the top, then take two results.
        force dut.frame_count_q = 16'hFFFE;
        @(negedge clock);
        release dut.frame_count_q;
        @(negedge clock);
        checkOutput("wrap_preload", 32'(frame_count), 32'h0000_FFFE);
        fs = '{32'd1, 32'd2, 32'd3, 32'd40, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10};
        applyStimulus(fs, gp);
        expectResult("wrap1", 4'd3, 32'd40);
        takeResult("wrap1", 16'hFFFF);
        fs = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd99, 32'd10};
        applyStimulus(fs, gp);
        expectResult("wrap2", 4'd8, 32'd99);
        takeResult("wrap2", 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
